sb_rx_crc_ctrl: RTL and testbench

Sideband receive transaction controller that sits between the serial sideband receive line and the CRC-16 receive checker.
- Deserializes 10-bit symbols (start 0, 8 data bits LSB first, stop 1).
- Frames transactions of the form DLE, STX, LEN, payload[LEN], CRC_lo, CRC_hi, DLE, ETX.
- Sequences the checker by replaying each CRC-covered symbol bit-serially with crc_en held high, then samples the checker's error flag.
- Delivers payload bytes and reports a per-transaction status.

---
 rtl/sb_rx_crc_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sb_rx_crc_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_rx_crc_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sb_rx_crc_ctrl
//
// Sideband receive transaction controller. Deserializes 10-bit line symbols
// (start 0, 8 data bits LSB first, stop 1) and frames transactions of the form
//   DLE STX LEN payload[LEN] CRC_lo CRC_hi DLE ETX.
// Every CRC-covered symbol (STX..CRC_hi) is replayed bit-serially to an external
// CRC-16 checker during the 10 cycles after it was received. The checker's error
// flag is sampled once the replay ends. Payload bytes and a per-transaction
// status are delivered.
//
// Ports
//   sb_clk      sideband clock, one line bit per cycle
//   rst         synchronous, active-high reset
//   sb_rx_bit   serial line (pre-synchronized, idle 1)
//   crc_error   error flag from the CRC-16 receive checker
//   crc_ser     serial bit to the checker (1 when not replaying)
//   crc_en      checker enable, high while covered symbols are replayed
//   rx_byte     payload byte, qualified by rx_byte_vld (one-cycle strobe)
//   rx_len      LEN of the current transaction
//   trans_done  one-cycle strobe at completion or abort
//   trans_err   qualifies trans_done: 1 = transaction failed
//   err_code    0 none, 1 CRC, 2 framing, 3 length (valid with trans_done)
// -----------------------------------------------------------------------------
module sb_rx_crc_ctrl #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] DLE     = 8'hFE,
    parameter logic [7:0] STX     = 8'h05,
    parameter logic [7:0] ETX     = 8'h40
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sb_rx_bit,
    input  logic       crc_error,
    output logic       crc_ser,
    output logic       crc_en,
    output logic [7:0] rx_byte,
    output logic       rx_byte_vld,
    output logic [7:0] rx_len,
    output logic       trans_done,
    output logic       trans_err,
    output logic [1:0] err_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GOT_DLE = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CRC0    = 3'd4;
    localparam logic [2:0] S_CRC1    = 3'd5;
    localparam logic [2:0] S_END_DLE = 3'd6;
    localparam logic [2:0] S_END_ETX = 3'd7;

    localparam logic [1:0] E_CRC = 2'd1;
    localparam logic [1:0] E_FRM = 2'd2;
    localparam logic [1:0] E_LEN = 2'd3;

    // Deserializer
    logic       armed;      // set once the line has been seen high after reset
    logic       busy;
    logic [3:0] bit_cnt;
    logic [7:0] sh;
    logic       sym_done;
    logic       stop_ok;

    // Frame control
    logic [2:0] state, state_nxt;
    logic [7:0] pay_cnt;
    logic       gap_chk;    // next cycle must carry the following start bit
    logic       crc_bad;

    // Replay
    logic [8:0] rep_sr;
    logic [3:0] rep_cnt;
    logic       hi_rep;     // current replay is CRC_hi; its end triggers sampling
    logic [1:0] samp_sr;

    // Decoded actions for this cycle
    logic       load_rep, set_gap, set_hi, accept_len, deliver, complete;
    logic       abort;
    logic [1:0] abort_code;

    assign sym_done = busy && (bit_cnt == 4'd9);
    assign stop_ok  = sb_rx_bit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            armed   <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= 4'd0;
            sh      <= 8'd0;
        end else if (!busy) begin
            if (sb_rx_bit)
                armed <= 1'b1;
            else if (armed) begin
                busy    <= 1'b1;
                bit_cnt <= 4'd1;
            end
        end else if (bit_cnt == 4'd9) begin
            busy    <= 1'b0;
            bit_cnt <= 4'd0;
        end else begin
            sh      <= {sb_rx_bit, sh[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        load_rep   = 1'b0;
        set_gap    = 1'b0;
        set_hi     = 1'b0;
        accept_len = 1'b0;
        deliver    = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        abort_code = 2'd0;
        if (gap_chk && sb_rx_bit) begin
            abort      = 1'b1;
            abort_code = E_FRM;
        end else if (sym_done) begin
            case (state)
                S_IDLE:
                    if (stop_ok && sh == DLE) state_nxt = S_GOT_DLE;
                S_GOT_DLE:
                    if (stop_ok && sh == STX) begin
                        state_nxt = S_LEN;
                        load_rep  = 1'b1;
                        set_gap   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                S_LEN:
                    if (!stop_ok) begin
                        abort = 1'b1; abort_code = E_FRM;
                    end else if (sh != 8'd0 && sh <= MAX_LEN_B) begin
                        state_nxt  = S_PAYLOAD;
                        accept_len = 1'b1;
                        load_rep   = 1'b1;
                        set_gap    = 1'b1;
                    end else begin
                        abort = 1'b1; abort_code = E_LEN;
                    end
                S_PAYLOAD:
                    if (!stop_ok) begin
                        abort = 1'b1; abort_code = E_FRM;
                    end else begin
                        deliver  = 1'b1;
                        load_rep = 1'b1;
                        set_gap  = 1'b1;
                        if (pay_cnt + 8'd1 == rx_len) state_nxt = S_CRC0;
                    end
                S_CRC0:
                    if (!stop_ok) begin
                        abort = 1'b1; abort_code = E_FRM;
                    end else begin
                        state_nxt = S_CRC1;
                        load_rep  = 1'b1;
                        set_gap   = 1'b1;
                    end
                S_CRC1:
                    if (!stop_ok) begin
                        abort = 1'b1; abort_code = E_FRM;
                    end else begin
                        state_nxt = S_END_DLE;
                        load_rep  = 1'b1;
                        set_hi    = 1'b1;
                    end
                S_END_DLE:
                    if (!stop_ok || sh != DLE) begin
                        abort = 1'b1; abort_code = E_FRM;
                    end else begin
                        state_nxt = S_END_ETX;
                    end
                default: // S_END_ETX
                    if (!stop_ok || sh != ETX) begin
                        abort = 1'b1; abort_code = E_FRM;
                    end else begin
                        complete  = 1'b1;
                        state_nxt = S_IDLE;
                    end
            endcase
        end
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pay_cnt     <= 8'd0;
            gap_chk     <= 1'b0;
            crc_bad     <= 1'b0;
            rx_byte     <= 8'd0;
            rx_byte_vld <= 1'b0;
            rx_len      <= 8'd0;
            trans_done  <= 1'b0;
            trans_err   <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            state       <= state_nxt;
            gap_chk     <= set_gap;
            rx_byte_vld <= deliver;
            trans_done  <= abort | complete;
            trans_err   <= abort | (complete & crc_bad);
            if (abort)
                err_code <= abort_code;
            else if (complete && crc_bad)
                err_code <= E_CRC;
            else
                err_code <= 2'd0;
            if (accept_len) begin
                rx_len  <= sh;
                pay_cnt <= 8'd0;
            end
            if (deliver) begin
                rx_byte <= sh;
                pay_cnt <= pay_cnt + 8'd1;
            end
            // A new STX starts a fresh checker run; the old verdict is stale.
            if (state == S_GOT_DLE && load_rep)
                crc_bad <= 1'b0;
            else if (samp_sr[1])
                crc_bad <= crc_error;
        end
    end

    // Replay: start bit goes out in the cycle after sym_done, then the eight
    // data bits and the stop bit. Back-to-back symbols reload exactly when the
    // previous replay finishes, keeping crc_en continuous.
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            crc_en  <= 1'b0;
            crc_ser <= 1'b1;
            rep_sr  <= 9'd0;
            rep_cnt <= 4'd0;
            hi_rep  <= 1'b0;
            samp_sr <= 2'b00;
        end else begin
            samp_sr <= {samp_sr[0], 1'b0};
            if (abort) begin
                crc_en  <= 1'b0;
                crc_ser <= 1'b1;
                rep_cnt <= 4'd0;
                hi_rep  <= 1'b0;
                samp_sr <= 2'b00;
            end else if (load_rep) begin
                crc_en  <= 1'b1;
                crc_ser <= 1'b0;
                rep_sr  <= {sb_rx_bit, sh};
                rep_cnt <= 4'd9;
                hi_rep  <= set_hi;
            end else if (rep_cnt != 4'd0) begin
                crc_ser <= rep_sr[0];
                rep_sr  <= {1'b1, rep_sr[8:1]};
                rep_cnt <= rep_cnt - 4'd1;
            end else begin
                crc_en  <= 1'b0;
                crc_ser <= 1'b1;
                // crc_en falls now (cycle F); crc_error is captured during F+1.
                if (crc_en && hi_rep) begin
                    samp_sr <= {samp_sr[0], 1'b1};
                    hi_rep  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_rx_crc_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sb_rx_crc_ctrl
//
// Drives framed sideband transactions into sb_rx_crc_ctrl and models the
// external CRC-16 receive checker (reflected poly 0xA001, init 0; a frame
// carrying its own CRC lo/hi leaves a zero residue). Expected bytes and status
// come from the frame description itself.
// -----------------------------------------------------------------------------
module tb_sb_rx_crc_ctrl;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] DLE     = 8'hFE;
    localparam logic [7:0] STX     = 8'h05;
    localparam logic [7:0] ETX     = 8'h40;

    // Status encodings {trans_err, err_code}
    localparam int ST_OK  = 0;
    localparam int ST_CRC = 5;
    localparam int ST_FRM = 6;
    localparam int ST_LEN = 7;

    logic       sb_clk = 1'b0;
    logic       rst;
    logic       sb_rx_bit;
    logic       crc_error;
    logic       crc_ser;
    logic       crc_en;
    logic [7:0] rx_byte;
    logic       rx_byte_vld;
    logic [7:0] rx_len;
    logic       trans_done;
    logic       trans_err;
    logic [1:0] err_code;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 sb_clk = ~sb_clk;

    sb_rx_crc_ctrl #(.MAX_LEN(MAX_LEN), .DLE(DLE), .STX(STX), .ETX(ETX)) dut (
        .sb_clk      (sb_clk),
        .rst         (rst),
        .sb_rx_bit   (sb_rx_bit),
        .crc_error   (crc_error),
        .crc_ser     (crc_ser),
        .crc_en      (crc_en),
        .rx_byte     (rx_byte),
        .rx_byte_vld (rx_byte_vld),
        .rx_len      (rx_len),
        .trans_done  (trans_done),
        .trans_err   (trans_err),
        .err_code    (err_code)
    );

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
        return c;
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        for (int i = 0; i < 8; i++) c = crc_bit(c, b[i]);
        return c;
    endfunction

    // ---------------- CRC-16 checker model ----------------
    // Bit counter 0..9 per symbol; only bits 1..8 (data) feed the CRC.
    // A rising crc_en starts a fresh run; state is held while disabled.
    logic [15:0] chk_crc     = 16'h0;
    int          chk_idx     = 0;
    logic        chk_en_prev = 1'b0;

    always @(posedge sb_clk) begin
        int          idx;
        logic [15:0] c;
        if (crc_en) begin
            idx = chk_en_prev ? chk_idx : 0;
            c   = chk_en_prev ? chk_crc : 16'h0;
            if (idx >= 1 && idx <= 8) c = crc_bit(c, crc_ser);
            chk_crc <= c;
            chk_idx <= (idx == 9) ? 0 : idx + 1;
        end
        chk_en_prev <= crc_en;
    end

    assign crc_error = (chk_crc != 16'h0);

    // ---------------- Monitor ----------------
    logic [7:0] got_q[$];
    int         done_q[$];
    int         en_cycles, en_run, en_max, done_en_hi;

    always @(negedge sb_clk) begin
        if (!rst) begin
            if (rx_byte_vld) got_q.push_back(rx_byte);
            if (trans_done) begin
                done_q.push_back(int'({trans_err, err_code}));
                if (crc_en) done_en_hi++;
            end
            if (crc_en) begin
                en_cycles++;
                en_run++;
                if (en_run > en_max) en_max = en_run;
            end else begin
                en_run = 0;
            end
        end
    end

    task automatic clear_mon();
        @(posedge sb_clk);
        got_q.delete();
        done_q.delete();
        en_cycles  = 0;
        en_run     = 0;
        en_max     = 0;
        done_en_hi = 0;
    endtask

    // ---------------- Stimulus ----------------
    logic [7:0] pl_q[$];   // payload of the next frame
    logic [7:0] exp_q[$];  // expected delivered bytes

    function automatic bit bytes_match();
        if (got_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic send_sym(input logic [7:0] b);
        @(negedge sb_clk) sb_rx_bit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sb_clk) sb_rx_bit = b[i];
        end
        @(negedge sb_clk) sb_rx_bit = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sb_clk) sb_rx_bit = 1'b1;
        end
    endtask

    // Sends DLE STX LEN pl_q CRC DLE etx. An out-of-range LEN sends only the
    // header; a gap after payload index gap_after ends the frame right there.
    task automatic send_frame(input logic [7:0] len_field, input logic [15:0] crc_xor,
                              input int gap_after, input logic [7:0] etx);
        logic [15:0] c;
        c = crc_byte(16'h0, STX);
        c = crc_byte(c, len_field);
        foreach (pl_q[i]) c = crc_byte(c, pl_q[i]);
        c = c ^ crc_xor;
        send_sym(DLE);
        send_sym(STX);
        send_sym(len_field);
        if (len_field == 8'd0 || int'(len_field) > MAX_LEN) return;
        foreach (pl_q[i]) begin
            send_sym(pl_q[i]);
            if (i == gap_after) begin
                idle(1);
                return;
            end
        end
        send_sym(c[7:0]);
        send_sym(c[15:8]);
        send_sym(DLE);
        send_sym(etx);
    endtask

    task automatic rand_payload(input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        logic [22:0] outs;
        clear_mon();
        rst = 1'b1;
        sb_rx_bit = 1'b0;
        repeat (4) @(negedge sb_clk);
        outs = {crc_ser, crc_en, rx_byte, rx_byte_vld, rx_len, trans_done, trans_err, err_code};
        tests_run++;
        if (outs !== {1'b1, 22'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%h exp=%h", outs, {1'b1, 22'd0});
        end
        rst = 1'b0;
        // Line held low after reset: no start may be taken until it goes high.
        repeat (14) @(negedge sb_clk);
        outs = {crc_ser, crc_en, rx_byte, rx_byte_vld, rx_len, trans_done, trans_err, err_code};
        tests_run++;
        if (outs !== {1'b1, 22'd0}) begin
            tests_failed++;
            $display("FAIL reset_line_low got=%h exp=%h", outs, {1'b1, 22'd0});
        end
        idle(1);
        pl_q = '{8'hA1, 8'hB2};
        exp_q = pl_q;
        send_frame(8'd2, 16'h0, -1, ETX);
        idle(15);
        tests_run++;
        if (!bytes_match()) begin
            tests_failed++;
            $display("FAIL basic_bytes got_n=%0d exp_n=%0d", got_q.size(), exp_q.size());
        end
        tests_run++;
        if (done_q.size() != 1 || done_q[0] != ST_OK) begin
            tests_failed++;
            $display("FAIL basic_status got_n=%0d first=%0d exp=%0d", done_q.size(),
                     done_q.size() ? done_q[0] : -1, ST_OK);
        end
        tests_run++;
        if (rx_len !== 8'd2) begin
            tests_failed++;
            $display("FAIL basic_rx_len got=%0d exp=2", rx_len);
        end
        tests_run++;
        if (en_cycles != 60 || en_max != 60) begin
            tests_failed++;
            $display("FAIL basic_crc_en got_total=%0d got_run=%0d exp=60", en_cycles, en_max);
        end
    endtask

    task automatic test_crc_error();
        clear_mon();
        pl_q = '{8'hA1, 8'hB2};
        exp_q = pl_q;
        send_frame(8'd2, 16'h0008, -1, ETX);
        idle(15);
        tests_run++;
        if (done_q.size() != 1 || done_q[0] != ST_CRC) begin
            tests_failed++;
            $display("FAIL crc_status got_n=%0d first=%0d exp=%0d", done_q.size(),
                     done_q.size() ? done_q[0] : -1, ST_CRC);
        end
        tests_run++;
        if (!bytes_match()) begin
            tests_failed++;
            $display("FAIL crc_bytes got_n=%0d exp_n=%0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_length();
        logic [7:0] bad_len[2];
        bad_len[0] = 8'd0;
        bad_len[1] = 8'(MAX_LEN + 1);
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            rand_payload(2);
            send_frame(bad_len[k], 16'h0, -1, ETX);
            idle(15);
            tests_run++;
            if (done_q.size() != 1 || done_q[0] != ST_LEN || got_q.size() != 0 || done_en_hi != 0) begin
                tests_failed++;
                $display("FAIL len_abort len=%0d got_n=%0d first=%0d exp=%0d bytes=%0d en_hi=%0d",
                         bad_len[k], done_q.size(), done_q.size() ? done_q[0] : -1, ST_LEN,
                         got_q.size(), done_en_hi);
            end
        end
        clear_mon();
        rand_payload(MAX_LEN);
        exp_q = pl_q;
        send_frame(8'(MAX_LEN), 16'h0, -1, ETX);
        idle(15);
        tests_run++;
        if (done_q.size() != 1 || done_q[0] != ST_OK || !bytes_match()) begin
            tests_failed++;
            $display("FAIL len_max got_n=%0d first=%0d exp=%0d bytes=%0d/%0d", done_q.size(),
                     done_q.size() ? done_q[0] : -1, ST_OK, got_q.size(), exp_q.size());
        end
        tests_run++;
        if (rx_len !== 8'(MAX_LEN) || en_cycles != 10 * (MAX_LEN + 4)) begin
            tests_failed++;
            $display("FAIL len_max_len got=%0d/%0d exp=%0d/%0d", rx_len, en_cycles,
                     MAX_LEN, 10 * (MAX_LEN + 4));
        end
    endtask

    task automatic test_framing();
        // Idle bit after the first of three payload bytes.
        clear_mon();
        pl_q = '{8'h11, 8'h22, 8'h33};
        exp_q = '{8'h11};
        send_frame(8'd3, 16'h0, 0, ETX);
        idle(15);
        tests_run++;
        if (done_q.size() != 1 || done_q[0] != ST_FRM || done_en_hi != 0) begin
            tests_failed++;
            $display("FAIL gap_status got_n=%0d first=%0d exp=%0d en_hi=%0d", done_q.size(),
                     done_q.size() ? done_q[0] : -1, ST_FRM, done_en_hi);
        end
        tests_run++;
        if (!bytes_match()) begin
            tests_failed++;
            $display("FAIL gap_bytes got_n=%0d exp_n=%0d", got_q.size(), exp_q.size());
        end
        // ETX replaced by 0x41.
        clear_mon();
        pl_q = '{8'h11, 8'h22, 8'h33};
        exp_q = pl_q;
        send_frame(8'd3, 16'h0, -1, 8'h41);
        idle(15);
        tests_run++;
        if (done_q.size() != 1 || done_q[0] != ST_FRM || done_en_hi != 0 || !bytes_match()) begin
            tests_failed++;
            $display("FAIL etx_status got_n=%0d first=%0d exp=%0d bytes=%0d/%0d", done_q.size(),
                     done_q.size() ? done_q[0] : -1, ST_FRM, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        int          len;
        int          exp_st;
        logic [15:0] flip;
        for (int it = 0; it < 6; it++) begin
            clear_mon();
            len = $urandom_range(1, MAX_LEN);
            rand_payload(len);
            pl_q[$urandom_range(0, len - 1)] = DLE;  // DLE inside payload is data
            flip   = ($urandom_range(0, 1) == 1) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            exp_st = (flip != 16'h0) ? ST_CRC : ST_OK;
            exp_q  = pl_q;
            send_frame(8'(len), flip, -1, ETX);
            idle(15);
            tests_run++;
            if (done_q.size() != 1 || done_q[0] != exp_st || !bytes_match()) begin
                tests_failed++;
                $display("FAIL rand_frame it=%0d len=%0d got_n=%0d first=%0d exp=%0d bytes=%0d/%0d",
                         it, len, done_q.size(), done_q.size() ? done_q[0] : -1, exp_st,
                         got_q.size(), exp_q.size());
            end
            tests_run++;
            if (rx_len !== 8'(len) || en_cycles != 10 * (len + 4) || en_max != 10 * (len + 4)) begin
                tests_failed++;
                $display("FAIL rand_len it=%0d got=%0d/%0d/%0d exp=%0d/%0d", it, rx_len,
                         en_cycles, en_max, len, 10 * (len + 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        int len_a, len_b;
        clear_mon();
        len_a = $urandom_range(1, 6);
        len_b = $urandom_range(1, 6);
        rand_payload(len_a);
        exp_q = pl_q;
        send_frame(8'(len_a), 16'h0, -1, ETX);
        rand_payload(len_b);
        foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
        send_frame(8'(len_b), 16'h0, -1, ETX);  // DLE follows ETX with no idle bit
        idle(15);
        tests_run++;
        if (done_q.size() != 2 || done_q[0] != ST_OK || done_q[1] != ST_OK) begin
            tests_failed++;
            $display("FAIL b2b_status got_n=%0d exp_n=2 exp=%0d", done_q.size(), ST_OK);
        end
        tests_run++;
        if (!bytes_match() || en_cycles != 10 * (len_a + len_b + 8)) begin
            tests_failed++;
            $display("FAIL b2b_bytes got_n=%0d exp_n=%0d en=%0d exp_en=%0d", got_q.size(),
                     exp_q.size(), en_cycles, 10 * (len_a + len_b + 8));
        end
    endtask

    task automatic test_rst_mid();
        logic [1:0] obs;
        clear_mon();
        rand_payload(4);
        send_sym(DLE);
        send_sym(STX);
        send_sym(8'd4);
        send_sym(pl_q[0]);
        send_sym(pl_q[1]);
        @(negedge sb_clk) sb_rx_bit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sb_clk) sb_rx_bit = pl_q[2][i];
        end
        @(negedge sb_clk);
        rst = 1'b1;
        sb_rx_bit = 1'b1;
        @(negedge sb_clk);
        obs = {crc_en, trans_done};
        tests_run++;
        if (obs !== 2'b00 || crc_ser !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs got=%b/%b exp=00/1", obs, crc_ser);
        end
        rst = 1'b0;
        idle(20);
        tests_run++;
        if (done_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_done got_n=%0d exp_n=0", done_q.size());
        end
        clear_mon();
        rand_payload(3);
        exp_q = pl_q;
        send_frame(8'd3, 16'h0, -1, ETX);
        idle(15);
        tests_run++;
        if (done_q.size() != 1 || done_q[0] != ST_OK || !bytes_match()) begin
            tests_failed++;
            $display("FAIL rst_mid_recover got_n=%0d first=%0d exp=%0d bytes=%0d/%0d",
                     done_q.size(), done_q.size() ? done_q[0] : -1, ST_OK,
                     got_q.size(), exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        sb_rx_bit = 1'b0;
        test_reset();
        test_crc_error();
        test_length();
        test_framing();
        test_random();
        test_back_to_back();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
